// File: rtl/ohc_5_forward_converter.sv
// ohc_5_forward_converter
// Bit-serial W-bit unsigned binary to one-hot residue mod 5 converter.
// The operand is consumed MSB first, one bit per clock. The residue is kept
// in one-hot form throughout: doubling is a fixed wire permutation and adding
// a 1 bit is a rotate-left by one position.
//
// Optional feature macro: OHC5_BIN_OUT_EN adds out_bin[2:0], the registered
// binary encoding of out_res, qualified by the same out_valid.
//
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high. in_ready is high only in IDLE, so operands never overlap.
// out_valid is held, with out_res and out_bin stable, until out_ready is seen.
//
// The FSM state is kept in the enum signal "state" so checkers can observe it.
module ohc_5_forward_converter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [4:0]   out_res
`ifdef OHC5_BIN_OUT_EN
  ,
  output logic [2:0]   out_bin
`endif
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  logic [W-1:0]  sh;
  logic [CW-1:0] cnt;
  logic [4:0]    r;
  logic [4:0]    r_dbl;
  logic [4:0]    r_next;

  // One residue step r <- (2r + b) mod 5 in one-hot form, b = current MSB.
  // Doubling maps index 0->0, 1->2, 2->4, 3->1, 4->3.
  always_comb begin
    r_dbl  = {r[2], r[4], r[1], r[3], r[0]};
    r_next = r_dbl;
    if (sh[W-1]) begin
      r_next = {r_dbl[3:0], r_dbl[4]};
    end
  end

  // Accept gating is combinational on rst_n so in_ready is low during reset
  // and high on the very first cycle after release.
  assign in_ready = rst_n && (state == IDLE);
  assign out_res  = r;

  // Converter FSM: accept operand, shift W bits, hold residue until taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      r         <= 5'b00001;
      cnt       <= '0;
      sh        <= '0;
`ifdef OHC5_BIN_OUT_EN
      out_bin   <= 3'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sh    <= in_data;
            r     <= 5'b00001;
            cnt   <= CW'(W - 1);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          r   <= r_next;
          sh  <= {sh[W-2:0], 1'b0};
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
`ifdef OHC5_BIN_OUT_EN
            out_bin   <= {r_next[4], r_next[2] | r_next[3], r_next[1] | r_next[3]};
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
